// File: rtl/hdlc_rx_channel.sv
`default_nettype none
// ============================================================================
// Module  : hdlc_rx_channel
// Brief   : HDLC serial receive front end. Detects flag, abort and idle,
//           removes stuffed zeros, and assembles LSB-first payload bytes.
// Revision: 1.0
// ============================================================================
module hdlc_rx_channel #(
  parameter int IDLE_LEN  = 15,
  parameter int STUFF_RUN = 5
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  output logic [7:0] Rx_Data,
  output logic       Rx_NewByte,
  output logic       Rx_ValidFrame,
  output logic       Rx_EoF,
  output logic       Rx_FlagDetect,
  output logic       Rx_AbortDetect,
  output logic       Rx_AbortSignal,
  output logic       Rx_FrameError,
  output logic       Rx_Idle
);

  localparam int                  c_ONES_W    = $clog2(IDLE_LEN + 1);
  localparam logic [c_ONES_W-1:0] c_IDLE_MAX  = c_ONES_W'(IDLE_LEN);
  localparam logic [c_ONES_W-1:0] c_STUFF_MAX = c_ONES_W'(STUFF_RUN);
  // Window bit [0] is the oldest bit on the line.
  localparam logic [7:0]          c_FLAG_PAT  = 8'b0111_1110;
  localparam logic [7:0]          c_ABORT_PAT = 8'b1111_1110;

  typedef enum logic [0:0] {
    HUNT  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t r_state;
  state_t w_stateNext;

  logic                r_rx;
  logic                r_rxVld;
  logic                r_rxTag;
  logic [c_ONES_W-1:0] r_ones;
  logic [7:0]          r_win;
  logic [7:0]          r_winVld;
  logic [7:0]          r_winTag;
  logic [2:0]          r_bitCnt;
  logic [6:0]          r_asm;
  logic                r_gotByte;
  logic                r_eofPend;
  logic                r_ferrPend;

  logic w_full;
  logic w_flag;
  logic w_abort;
  logic w_commit;
  logic w_startFrame;
  logic w_endFrame;
  logic w_abortFrame;

  assign w_full   = &r_winVld;
  assign w_flag   = w_full && (r_win == c_FLAG_PAT);
  assign w_abort  = w_full && (r_win == c_ABORT_PAT);
  assign w_commit = (r_state == FRAME) && r_winVld[0] && !r_winTag[0] && !w_flag && !w_abort;

  assign Rx_ValidFrame = (r_state == FRAME);
  assign Rx_Idle       = (r_ones == c_IDLE_MAX) && (r_state == HUNT);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    w_startFrame = 1'b0;
    w_endFrame   = 1'b0;
    w_abortFrame = 1'b0;
    case (r_state)
      HUNT: begin
        if (Rx_FlagDetect) begin
          w_stateNext  = FRAME;
          w_startFrame = 1'b1;
        end
      end
      FRAME: begin
        if (Rx_AbortDetect) begin
          w_stateNext  = HUNT;
          w_abortFrame = 1'b1;
        end else if (Rx_FlagDetect && (r_gotByte || (r_bitCnt != 3'd0))) begin
          // An empty frame between flags is just a repeated opening flag.
          w_stateNext = HUNT;
          w_endFrame  = 1'b1;
        end
      end
      default: w_stateNext = HUNT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rx           <= 1'b0;
      r_rxVld        <= 1'b0;
      r_rxTag        <= 1'b0;
      r_ones         <= '0;
      r_win          <= 8'h00;
      r_winVld       <= 8'h00;
      r_winTag       <= 8'h00;
      r_bitCnt       <= 3'd0;
      r_asm          <= 7'd0;
      r_gotByte      <= 1'b0;
      r_eofPend      <= 1'b0;
      r_ferrPend     <= 1'b0;
      Rx_Data        <= 8'h00;
      Rx_NewByte     <= 1'b0;
      Rx_EoF         <= 1'b0;
      Rx_FlagDetect  <= 1'b0;
      Rx_AbortDetect <= 1'b0;
      Rx_AbortSignal <= 1'b0;
      Rx_FrameError  <= 1'b0;
    end else begin
      r_rx    <= Rx;
      r_rxVld <= 1'b1;
      r_rxTag <= (Rx == 1'b0) && (r_ones == c_STUFF_MAX);
      if (Rx == 1'b0) begin
        r_ones <= '0;
      end else if (r_ones != c_IDLE_MAX) begin
        r_ones <= r_ones + 1'b1;
      end

      // A detected pattern is flushed so none of its bits reach the assembler.
      if (w_flag || w_abort) begin
        r_win    <= {r_rx, 7'd0};
        r_winVld <= {r_rxVld, 7'd0};
        r_winTag <= {r_rxTag, 7'd0};
      end else begin
        r_win    <= {r_rx, r_win[7:1]};
        r_winVld <= {r_rxVld, r_winVld[7:1]};
        r_winTag <= {r_rxTag, r_winTag[7:1]};
      end
      Rx_FlagDetect  <= w_flag;
      Rx_AbortDetect <= w_abort;

      Rx_NewByte <= 1'b0;
      if (w_startFrame || w_endFrame || w_abortFrame) begin
        r_bitCnt  <= 3'd0;
        r_gotByte <= 1'b0;
      end else if (w_commit) begin
        r_asm    <= {r_win[0], r_asm[6:1]};
        r_bitCnt <= r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7) begin
          Rx_Data    <= {r_win[0], r_asm};
          Rx_NewByte <= 1'b1;
          r_gotByte  <= 1'b1;
        end
      end

      Rx_AbortSignal <= w_abortFrame;
      r_eofPend      <= w_endFrame || w_abortFrame;
      r_ferrPend     <= w_endFrame && (r_bitCnt != 3'd0);
      Rx_EoF         <= r_eofPend;
      Rx_FrameError  <= r_ferrPend;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hdlc_rx_channel.sv
`default_nettype none
// ============================================================================
// Module  : tb_hdlc_rx_channel
// Brief   : Directed and random HDLC line streams checked cycle by cycle
//           against a queue-based receiver model.
// Revision: 1.0
// ============================================================================
module tb_hdlc_rx_channel;
  localparam int MAXC      = 20000;
  localparam int IDLE_LEN  = 15;
  localparam int STUFF_RUN = 5;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx  = 1'b1;
  logic [7:0] Rx_Data;
  logic       Rx_NewByte, Rx_ValidFrame, Rx_EoF, Rx_FlagDetect;
  logic       Rx_AbortDetect, Rx_AbortSignal, Rx_FrameError, Rx_Idle;

  hdlc_rx_channel #(.IDLE_LEN(IDLE_LEN), .STUFF_RUN(STUFF_RUN)) dut (
    .Clk(Clk), .Rst(Rst), .Rx(Rx),
    .Rx_Data(Rx_Data), .Rx_NewByte(Rx_NewByte), .Rx_ValidFrame(Rx_ValidFrame),
    .Rx_EoF(Rx_EoF), .Rx_FlagDetect(Rx_FlagDetect), .Rx_AbortDetect(Rx_AbortDetect),
    .Rx_AbortSignal(Rx_AbortSignal), .Rx_FrameError(Rx_FrameError), .Rx_Idle(Rx_Idle)
  );

  always #5 Clk = ~Clk;

  bit         stRst [MAXC];
  bit         stRx  [MAXC];
  bit         eFlag [MAXC];
  bit         eAbort[MAXC];
  bit         eAbSig[MAXC];
  bit         eEof  [MAXC];
  bit         eFerr [MAXC];
  bit         eNb   [MAXC];
  bit         eVf   [MAXC];
  bit         eIdle [MAXC];
  logic [7:0] eByte [MAXC];
  logic [7:0] eData [MAXC];
  int         onesAt[MAXC];
  int         evVf  [MAXC];
  int nCyc = 0, txOnes = 0, nVec = 0, nBad = 0, cyc = 0;
  bit run = 1'b0;

  task automatic addBit(input bit r, input bit b);
    if (nCyc < MAXC - 8) begin
      stRst[nCyc] = r;
      stRx[nCyc]  = b;
      nCyc++;
    end
  endtask

  task automatic rawBits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) addBit(1'b0, v[i]);
    txOnes = 0;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) addBit(1'b0, 1'b1);
    txOnes = 0;
  endtask

  task automatic flag();      rawBits(8'h7E, 8); endtask
  task automatic abortSeq();  rawBits(8'hFE, 8); endtask

  task automatic rstCycles(input int n);
    for (int i = 0; i < n; i++) addBit(1'b1, 1'b1);
    txOnes = 0;
  endtask

  // Transmitter-side bit stuffing: a zero follows every run of five data ones.
  task automatic dataBit(input bit b);
    addBit(1'b0, b);
    if (b) begin
      txOnes++;
      if (txOnes == STUFF_RUN) begin
        addBit(1'b0, 1'b0);
        txOnes = 0;
      end
    end else begin
      txOnes = 0;
    end
  endtask

  task automatic byteTx(input logic [7:0] v);
    for (int i = 0; i < 8; i++) dataBit(v[i]);
  endtask

  // Model: bit g is sampled at edge g and joins the 8-bit window at edge g+1;
  // a full-window match is reported at edge g+2 and discards the window.
  task automatic runModel();
    int ones = 0, resid = 0, bytes = 0;
    bit q[$];
    bit qt[$];
    bit pend = 0, pendFlag = 0, inFrame = 0, b, tg, ob, ot;
    logic [7:0] acc = 8'h00, w;
    int e;
    logic [7:0] data = 8'h00;
    bit vf = 0;
    for (int g = 0; g < nCyc; g++) begin
      if (stRst[g]) begin
        for (int k = g; k <= g + 3 && k < MAXC; k++) begin
          eFlag[k] = 0; eAbort[k] = 0; eAbSig[k] = 0; eEof[k] = 0;
          eFerr[k] = 0; eNb[k] = 0; evVf[k] = 0;
        end
        evVf[g] = 2; onesAt[g] = 0;
        ones = 0; resid = 0; bytes = 0; pend = 0; inFrame = 0;
        q.delete(); qt.delete();
        continue;
      end
      b  = stRx[g];
      tg = !b && (ones == STUFF_RUN);
      ones = b ? ((ones + 1 > IDLE_LEN) ? IDLE_LEN : ones + 1) : 0;
      onesAt[g] = ones;
      e = g + 1;
      if (pend) begin
        q.delete(); qt.delete();
        q.push_back(b); qt.push_back(tg);
        pend = 0;
        if (pendFlag) begin
          eFlag[e] = 1;
          if (!inFrame) begin
            inFrame = 1; evVf[e+1] = 1; resid = 0; bytes = 0;
          end else if (bytes != 0 || resid != 0) begin
            inFrame = 0; evVf[e+1] = 2; eEof[e+2] = 1; eFerr[e+2] = (resid != 0);
            resid = 0; bytes = 0;
          end
        end else begin
          eAbort[e] = 1;
          if (inFrame) begin
            inFrame = 0; evVf[e+1] = 2; eAbSig[e+1] = 1; eEof[e+2] = 1;
            resid = 0; bytes = 0;
          end
        end
      end else begin
        q.push_back(b); qt.push_back(tg);
        if (q.size() > 8) begin
          ob = q.pop_front(); ot = qt.pop_front();
          if (inFrame && !ot) begin
            acc[resid] = ob;
            resid++;
            if (resid == 8) begin
              eNb[e] = 1; eByte[e] = acc; bytes++; resid = 0;
            end
          end
        end
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) w[i] = q[i];
          if (w == 8'h7E) begin pend = 1; pendFlag = 1; end
          else if (w == 8'hFE) begin pend = 1; pendFlag = 0; end
        end
      end
    end
    for (int g = 0; g < nCyc; g++) begin
      if (stRst[g]) data = 8'h00;
      if (evVf[g] == 1) vf = 1;
      else if (evVf[g] == 2) vf = 0;
      if (eNb[g]) data = eByte[g];
      eVf[g]   = vf;
      eData[g] = data;
      eIdle[g] = (onesAt[g] == IDLE_LEN) && !vf;
    end
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s @cycle %0d: got %02h, want %02h", name, c, act, exp);
    end
  endtask

  function automatic int nbCount(input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (eNb[k]) n++;
    return n;
  endfunction

  function automatic logic [7:0] nbNth(input int lo, input int hi, input int nth);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (eNb[k]) begin
      if (n == nth) return eByte[k];
      n++;
    end
    return 8'hEE;
  endfunction

  function automatic int evCount(input int kind, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      case (kind)
        0:       n += int'(eEof[k]);
        1:       n += int'(eAbSig[k]);
        default: n += int'(eAbort[k]);
      endcase
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (run) begin
        chk("Rx_Data",        cyc, Rx_Data,        eData[cyc]);
        chk("Rx_NewByte",     cyc, Rx_NewByte,     eNb[cyc]);
        chk("Rx_ValidFrame",  cyc, Rx_ValidFrame,  eVf[cyc]);
        chk("Rx_EoF",         cyc, Rx_EoF,         eEof[cyc]);
        chk("Rx_FlagDetect",  cyc, Rx_FlagDetect,  eFlag[cyc]);
        chk("Rx_AbortDetect", cyc, Rx_AbortDetect, eAbort[cyc]);
        chk("Rx_AbortSignal", cyc, Rx_AbortSignal, eAbSig[cyc]);
        chk("Rx_FrameError",  cyc, Rx_FrameError,  eFerr[cyc]);
        chk("Rx_Idle",        cyc, Rx_Idle,        eIdle[cyc]);
      end
    end
  end

  initial begin
    int f1, f2, f3, f4, f5, a1, f6, f7, f8, f9, f10, r6, i6, nf, nb, nr;
    rstCycles(2);
    ones(16); flag(); f1 = nCyc - 1;
    byteTx(8'hA5); byteTx(8'h3C); flag(); f2 = nCyc - 1;
    ones(4); flag(); f3 = nCyc - 1;
    byteTx(8'hFF); flag(); f4 = nCyc - 1;
    ones(2); flag(); f5 = nCyc - 1;
    byteTx(8'h12); abortSeq(); a1 = nCyc - 1;
    ones(10); flag(); f6 = nCyc - 1;
    byteTx(8'h5A); dataBit(1'b1); dataBit(1'b0); dataBit(1'b1); flag(); f7 = nCyc - 1;
    ones(3); flag(); f8 = nCyc - 1; flag(); flag();
    byteTx(8'h7E); flag(); f9 = nCyc - 1;
    ones(2); flag(); f10 = nCyc - 1;
    byteTx(8'h33); for (int i = 0; i < 4; i++) dataBit(1'b1);
    rstCycles(1); r6 = nCyc - 1;
    ones(16); i6 = nCyc - 1;
    for (int fr = 0; fr < 140; fr++) begin
      if ($urandom_range(0, 29) == 0) rstCycles($urandom_range(1, 2));
      ones($urandom_range(0, 20));
      nf = $urandom_range(1, 3);
      for (int k = 0; k < nf; k++) flag();
      nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++) byteTx(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) begin
        nr = $urandom_range(1, 7);
        for (int k = 0; k < nr; k++) dataBit(1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 24) == 0) rstCycles(1);
      if ($urandom_range(0, 5) == 0) abortSeq(); else flag();
    end
    ones(20);
    runModel();

    chk("pin_idle_before_open", f1 - 8, eIdle[f1-8], 8'h01);
    chk("pin_open_flag_t2",     f1 + 2, eFlag[f1+2], 8'h01);
    chk("pin_valid_after_open", f1 + 3, eVf[f1+3], 8'h01);
    chk("pin_close_flag_t2",    f2 + 2, eFlag[f2+2], 8'h01);
    chk("pin_valid_at_close",   f2 + 2, eVf[f2+2], 8'h01);
    chk("pin_valid_falls",      f2 + 3, eVf[f2+3], 8'h00);
    chk("pin_eof_t1",           f2 + 4, eEof[f2+4], 8'h01);
    chk("pin_ferr_t1",          f2 + 4, eFerr[f2+4], 8'h00);
    chk("pin_nb_count_t1",      f2, 8'(nbCount(f1, f2 + 4)), 8'd2);
    chk("pin_byte0_t1",         f2, nbNth(f1, f2 + 4, 0), 8'hA5);
    chk("pin_byte1_t1",         f2, nbNth(f1, f2 + 4, 1), 8'h3C);
    chk("pin_nb_count_t2",      f4, 8'(nbCount(f3, f4 + 4)), 8'd1);
    chk("pin_byte_ff",          f4, nbNth(f3, f4 + 4, 0), 8'hFF);
    chk("pin_no_abort_t2",      f4, 8'(evCount(2, f3, f4 + 4)), 8'd0);
    chk("pin_abort_t2",         a1 + 2, eAbort[a1+2], 8'h01);
    chk("pin_abort_signal",     a1 + 3, eAbSig[a1+3], 8'h01);
    chk("pin_valid_abort",      a1 + 3, eVf[a1+3], 8'h00);
    chk("pin_eof_abort",        a1 + 4, eEof[a1+4], 8'h01);
    chk("pin_byte_12",          a1, nbNth(f5, a1 + 4, 0), 8'h12);
    chk("pin_nb_count_t3",      a1, 8'(nbCount(f5, a1 + 4)), 8'd1);
    chk("pin_eof_t4",           f7 + 4, eEof[f7+4], 8'h01);
    chk("pin_ferr_t4",          f7 + 4, eFerr[f7+4], 8'h01);
    chk("pin_byte_5a",          f7, nbNth(f6, f7 + 4, 0), 8'h5A);
    chk("pin_no_eof_flags",     f9, 8'(evCount(0, f8, f9 + 3)), 8'd0);
    chk("pin_eof_t5",           f9 + 4, eEof[f9+4], 8'h01);
    chk("pin_byte_7e",          f9, nbNth(f8, f9 + 4, 0), 8'h7E);
    chk("pin_nb_count_t5",      f9, 8'(nbCount(f8, f9 + 4)), 8'd1);
    chk("pin_rst_no_eof",       r6, 8'(evCount(0, r6, r6 + 6)), 8'd0);
    chk("pin_rst_no_abs",       r6, 8'(evCount(1, r6, r6 + 6)), 8'd0);
    chk("pin_rst_no_byte",      r6, 8'(nbCount(f10, r6 + 10)), 8'd0);
    chk("pin_rst_valid",        r6, eVf[r6], 8'h00);
    chk("pin_idle_14",          i6 - 2, eIdle[i6-2], 8'h00);
    chk("pin_idle_16",          i6, eIdle[i6], 8'h01);

    for (int g = 0; g < nCyc; g++) begin
      @(negedge Clk);
      Rst = stRst[g];
      Rx  = stRx[g];
      cyc = g;
      run = 1'b1;
    end
    @(negedge Clk);
    run = 1'b0;
    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
`default_nettype wire
